// File: rtl/latch_seq_pkg.sv
// Shared types and helpers for the latch load sequencer.
// The state encoding is fixed at two bits; max3 sizes the shared phase counter.
package latch_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    OPEN  = 2'd2,
    HOLD  = 2'd3
  } seq_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/latch_load_sequencer_phase_counter.sv
// Loadable down-counter shared by the SETUP, OPEN and HOLD phases.
// tc is high while the count is zero; the count parks at zero until reloaded.
module phase_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/latch_load_sequencer.sv
// Drives a transparent active-low-enable latch with ordered setup/pulse/hold phases.
// Optional macro LATCH_LOAD_SEQ_SKIP_EQ_EN: a word equal to the current latch_d skips the pulse.
module latch_load_sequencer
  import latch_seq_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 1,
  parameter int HOLD_CYC  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_in,
  input  logic             d_valid,
  output logic             d_ready,
  output logic [WIDTH-1:0] latch_d,
  output logic             latch_en_n,
  output logic             busy,
  output logic             load_done
);

  localparam int CNT_W = $clog2(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC) + 1);

  if (SETUP_CYC < 1) begin : g_bad_setup
    $error("latch_load_sequencer: SETUP_CYC must be at least 1");
  end
  if (PULSE_CYC < 1) begin : g_bad_pulse
    $error("latch_load_sequencer: PULSE_CYC must be at least 1");
  end
  if (HOLD_CYC < 1) begin : g_bad_hold
    $error("latch_load_sequencer: HOLD_CYC must be at least 1");
  end

  seq_state_e       state;
  seq_state_e       state_nxt;
  logic             accept;
  logic             skip;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             tc;

  assign d_ready = (state == IDLE) && !rst;
  assign accept  = d_valid && d_ready;

`ifdef LATCH_LOAD_SEQ_SKIP_EQ_EN
  assign skip = (d_in == latch_d);
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !skip) state_nxt = SETUP;
      SETUP:   if (tc) state_nxt = OPEN;
      OPEN:    if (tc) state_nxt = HOLD;
      HOLD:    if (tc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Each phase reloads the counter with its length minus one on entry.
  always_comb begin
    cnt_load = (state_nxt != state);
    cnt_val  = '0;
    case (state_nxt)
      SETUP:   cnt_val = CNT_W'(SETUP_CYC - 1);
      OPEN:    cnt_val = CNT_W'(PULSE_CYC - 1);
      HOLD:    cnt_val = CNT_W'(HOLD_CYC - 1);
      default: cnt_val = '0;
    endcase
  end

  phase_counter #(
    .CNT_W (CNT_W)
  ) u_phase_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .tc       (tc)
  );

  // Enable and busy come from the decoded next state so each is a single clean flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      latch_d    <= '0;
      latch_en_n <= 1'b1;
      busy       <= 1'b0;
      load_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      latch_en_n <= (state_nxt != OPEN);
      busy       <= (state_nxt != IDLE);
      load_done  <= ((state == HOLD) && (state_nxt == IDLE)) || (accept && skip);
      if (accept) begin
        latch_d <= d_in;
      end
    end
  end

endmodule
